// File: rtl/xcorr_lag_finder.sv
// Cross-correlation lag finder: captures one frame per microphone, then
// searches lags -MAX_LAG..+MAX_LAG with one MAC and reports the peak.
//
// Ports:
//   clk_60MHz    system clock, rising edge
//   rst_n        asynchronous active-low reset
//   sample_valid one sample pair on mic_a/mic_b this cycle
//   mic_a/mic_b  signed DW-bit samples
//   busy         high while correlating; incoming samples are dropped
//   lag_diff     signed 6-bit lag of the peak (positive: B lags A)
//   corr_peak    signed peak correlation value
//   ena          one-cycle pulse when lag_diff/corr_peak update
`timescale 1ns/1ps

module xcorr_lag_finder #(
    parameter int DW      = 16,
    parameter int FRAME   = 64,
    parameter int MAX_LAG = 15,
    parameter int ACC_W   = 2*DW+$clog2(FRAME)+1
) (
    input  logic             clk_60MHz,
    input  logic             rst_n,
    input  logic             sample_valid,
    input  logic [DW-1:0]    mic_a,
    input  logic [DW-1:0]    mic_b,
    output logic             busy,
    output logic [5:0]       lag_diff,
    output logic [ACC_W-1:0] corr_peak,
    output logic             ena
);

    localparam int AW   = $clog2(FRAME);
    localparam int NLAG = 2*MAX_LAG+1;
    localparam int KW   = 6;
    localparam int IW   = AW+KW+2;

    typedef enum logic [1:0] {
        S_CAPTURE,
        S_CALC,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // capture side
    logic [AW-1:0]        r_cnt;
    logic signed [DW-1:0] r_buf_a [FRAME];
    logic signed [DW-1:0] r_buf_b [FRAME];
    logic                 w_wr;
    logic                 w_cap_last;

    // issue counters: lag index 0..NLAG-1 maps to k = idx - MAX_LAG
    logic [KW-1:0] r_kidx;
    logic [AW-1:0] r_n;
    logic          w_issue;
    logic          w_n_last;
    logic [IW-1:0] w_bidx;
    logic          w_inr;

    // read stage
    logic                 r_s1_vld;
    logic                 r_s1_first;
    logic                 r_s1_last;
    logic [KW-1:0]        r_s1_k;
    logic signed [DW-1:0] r_s1_a;
    logic signed [DW-1:0] r_s1_b;

    // multiply stage
    logic                   r_s2_vld;
    logic                   r_s2_first;
    logic                   r_s2_last;
    logic [KW-1:0]          r_s2_k;
    logic signed [2*DW-1:0] r_prod;

    // accumulate / peak tracking
    logic signed [ACC_W-1:0] r_acc;
    logic [KW-1:0]           r_acc_k;
    logic                    r_acc_vld;
    logic signed [ACC_W-1:0] r_max;
    logic [KW-1:0]           r_arg_k;
    logic                    r_fin;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic                    w_take;

    // outputs
    logic [5:0]       r_lag_diff;
    logic [ACC_W-1:0] r_corr_peak;

    // a sample arriving in the DONE cycle starts the next frame
    assign w_wr = sample_valid &&
                  (r_state == S_CAPTURE || r_state == S_DONE);
    assign w_cap_last = w_wr && (r_cnt == AW'(FRAME-1));

    always_ff @(posedge clk_60MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_CAPTURE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_CAPTURE: if (w_cap_last) w_state_nxt = S_CALC;
            S_CALC:    if (r_fin)      w_state_nxt = S_DONE;
            S_DONE:                    w_state_nxt = S_CAPTURE;
            default:                   w_state_nxt = S_CAPTURE;
        endcase
    end

    always_ff @(posedge clk_60MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_wr) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // sample memories need no reset; contents are rewritten each frame
    always_ff @(posedge clk_60MHz) begin
        if (w_wr) begin
            r_buf_a[r_cnt] <= $signed(mic_a);
            r_buf_b[r_cnt] <= $signed(mic_b);
        end
    end

    assign w_issue  = (r_state == S_CALC) && (r_kidx < KW'(NLAG));
    assign w_n_last = (r_n == AW'(FRAME-1));
    assign w_bidx   = IW'(r_n) + IW'(r_kidx) - IW'(MAX_LAG);
    assign w_inr    = !w_bidx[IW-1] && (w_bidx < IW'(FRAME));

    always_ff @(posedge clk_60MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_kidx <= '0;
            r_n    <= '0;
        end else if (r_state != S_CALC) begin
            r_kidx <= '0;
            r_n    <= '0;
        end else if (w_issue) begin
            r_n <= r_n + 1'b1;
            if (w_n_last) begin
                r_kidx <= r_kidx + 1'b1;
            end
        end
    end

    // out-of-range B index contributes a zero term but keeps its slot
    always_ff @(posedge clk_60MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld   <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_k     <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else begin
            r_s1_vld   <= w_issue;
            r_s1_first <= (r_n == '0);
            r_s1_last  <= w_n_last && (r_kidx == KW'(NLAG-1));
            r_s1_k     <= r_kidx;
            r_s1_a     <= r_buf_a[r_n];
            r_s1_b     <= w_inr ? r_buf_b[w_bidx[AW-1:0]] : '0;
        end
    end

    always_ff @(posedge clk_60MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld   <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_k     <= '0;
            r_prod     <= '0;
        end else begin
            r_s2_vld   <= r_s1_vld;
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            r_s2_k     <= r_s1_k;
            r_prod     <= r_s1_a * r_s1_b;
        end
    end

    assign w_prod_ext = {{(ACC_W-2*DW){r_prod[2*DW-1]}}, r_prod};

    // first lag seeds the max; later lags win only when strictly larger
    assign w_take = (r_acc_k == '0) || (r_acc > r_max);

    always_ff @(posedge clk_60MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_acc_k   <= '0;
            r_acc_vld <= 1'b0;
            r_max     <= '0;
            r_arg_k   <= '0;
            r_fin     <= 1'b0;
        end else begin
            r_fin <= r_s2_vld && r_s2_last;
            if (r_state != S_CALC) begin
                r_acc_vld <= 1'b0;
            end else if (r_s2_vld) begin
                if (r_s2_first) begin
                    // previous lag's sum is complete: fold it into the max
                    r_acc     <= w_prod_ext;
                    r_acc_k   <= r_s2_k;
                    r_acc_vld <= 1'b1;
                    if (r_acc_vld && w_take) begin
                        r_max   <= r_acc;
                        r_arg_k <= r_acc_k;
                    end
                end else begin
                    r_acc <= r_acc + w_prod_ext;
                end
            end
        end
    end

    // last lag is compared here, in the same edge that enters DONE
    always_ff @(posedge clk_60MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_lag_diff  <= '0;
            r_corr_peak <= '0;
        end else if (r_fin) begin
            if (w_take) begin
                r_lag_diff  <= r_acc_k - 6'(MAX_LAG);
                r_corr_peak <= r_acc;
            end else begin
                r_lag_diff  <= r_arg_k - 6'(MAX_LAG);
                r_corr_peak <= r_max;
            end
        end
    end

    assign busy      = (r_state == S_CALC);
    assign ena       = (r_state == S_DONE);
    assign lag_diff  = r_lag_diff;
    assign corr_peak = r_corr_peak;

endmodule

// File: tb/tb_xcorr_lag_finder.sv
// Bench for xcorr_lag_finder: directed and random frames compared
// against a direct cross-correlation reference.
`timescale 1ns/1ps

module tb_xcorr_lag_finder;

    localparam int DW      = 16;
    localparam int FRAME   = 64;
    localparam int MAX_LAG = 15;
    localparam int ACC_W   = 2*DW+$clog2(FRAME)+1;
    localparam int LAT     = (2*MAX_LAG+1)*FRAME+3;

    logic             clk_60MHz = 1'b0;
    logic             rst_n = 1'b0;
    logic             sample_valid = 1'b0;
    logic [DW-1:0]    mic_a = '0;
    logic [DW-1:0]    mic_b = '0;
    logic             busy;
    logic [5:0]       lag_diff;
    logic [ACC_W-1:0] corr_peak;
    logic             ena;

    int n_tests = 0;
    int n_fail  = 0;
    int ena_cnt = 0;
    int frames  = 0;
    int ga [FRAME];
    int gb [FRAME];

    always #5 clk_60MHz = ~clk_60MHz;

    xcorr_lag_finder #(
        .DW(DW), .FRAME(FRAME), .MAX_LAG(MAX_LAG), .ACC_W(ACC_W)
    ) dut (
        .clk_60MHz(clk_60MHz),
        .rst_n(rst_n),
        .sample_valid(sample_valid),
        .mic_a(mic_a),
        .mic_b(mic_b),
        .busy(busy),
        .lag_diff(lag_diff),
        .corr_peak(corr_peak),
        .ena(ena)
    );

    always @(negedge clk_60MHz) begin
        if (ena === 1'b1) ena_cnt++;
    end

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model(output longint pk, output int lg);
        longint r;
        pk = 0;
        lg = -MAX_LAG;
        for (int k = -MAX_LAG; k <= MAX_LAG; k++) begin
            r = 0;
            for (int n = 0; n < FRAME; n++) begin
                if (n + k >= 0 && n + k < FRAME)
                    r += longint'(ga[n]) * longint'(gb[n+k]);
            end
            if (k == -MAX_LAG || r > pk) begin
                pk = r;
                lg = k;
            end
        end
    endfunction

    task automatic clear_frame();
        for (int n = 0; n < FRAME; n++) begin
            ga[n] = 0;
            gb[n] = 0;
        end
    endtask

    // B is A delayed by d samples, random fill where A has no sample
    task automatic rand_shift(input int d, input int amp);
        for (int n = 0; n < FRAME; n++)
            ga[n] = int'($urandom_range(2*amp, 0)) - amp;
        for (int n = 0; n < FRAME; n++) begin
            if (n - d >= 0 && n - d < FRAME) gb[n] = ga[n-d];
            else gb[n] = int'($urandom_range(2*amp, 0)) - amp;
        end
    endtask

    // now0: first sample is driven in the current cycle (DONE cycle)
    task automatic feed(input bit b2b, input bit now0);
        if (!now0) begin
            @(posedge clk_60MHz);
            #1;
        end
        for (int n = 0; n < FRAME; n++) begin
            sample_valid = 1'b1;
            mic_a = DW'(ga[n]);
            mic_b = DW'(gb[n]);
            @(posedge clk_60MHz);
            #1;
            sample_valid = 1'b0;
            if (!b2b && n < FRAME-1) begin
                @(posedge clk_60MHz);
                #1;
            end
        end
    endtask

    task automatic wait_ena(input bit inject, output int lat);
        lat = -1;
        for (int c = 1; c <= LAT + 200; c++) begin
            @(posedge clk_60MHz);
            #1;
            sample_valid = 1'b0;
            if (ena) begin
                lat = c;
                break;
            end
            if (inject && (c % 5 == 2) && c < LAT - 50) begin
                sample_valid = 1'b1;
                mic_a = DW'($urandom);
                mic_b = DW'($urandom);
            end
        end
    endtask

    task automatic run_frame(input string tag, input bit b2b,
                             input bit now0, input bit inject);
        longint pk;
        int     lg;
        int     lat;
        model(pk, lg);
        feed(b2b, now0);
        chk({tag, ".busy"}, longint'(busy), 1);
        wait_ena(inject, lat);
        chk({tag, ".lat"}, lat, LAT);
        chk({tag, ".lag"}, longint'($signed(lag_diff)), lg);
        chk({tag, ".peak"}, longint'($signed(corr_peak)), pk);
        chk({tag, ".idle"}, longint'(busy), 0);
        frames++;
    endtask

    initial begin
        int ec;
        repeat (3) @(posedge clk_60MHz);
        #1;
        chk("rst.busy", longint'(busy), 0);
        chk("rst.ena", longint'(ena), 0);
        chk("rst.lag", longint'(lag_diff), 0);
        chk("rst.peak", longint'(corr_peak), 0);
        rst_n = 1'b1;

        clear_frame(); ga[20] = 1000; gb[20] = 1000;
        run_frame("t1_same", 1'b0, 1'b0, 1'b0);
        chk("t1.lag_exact", longint'($signed(lag_diff)), 0);
        chk("t1.peak_exact", longint'($signed(corr_peak)), 1000000);

        clear_frame(); ga[20] = 1000; gb[25] = 1000;
        run_frame("t2_pos5", 1'b0, 1'b0, 1'b0);
        chk("t2.lag_bits", longint'(lag_diff), 5);

        clear_frame(); ga[30] = 1000; gb[23] = 1000;
        run_frame("t3_neg7", 1'b0, 1'b0, 1'b0);
        chk("t3.lag_bits", longint'(lag_diff), 57);

        clear_frame(); ga[30] = 1000; gb[50] = 1000;
        run_frame("t3_out", 1'b0, 1'b0, 1'b0);
        chk("t3o.lag_bits", longint'(lag_diff), 49);

        clear_frame();
        run_frame("t4_zero", 1'b0, 1'b0, 1'b0);
        chk("t4.lag_bits", longint'(lag_diff), 49);

        for (int n = 0; n < FRAME; n++) begin
            ga[n] = -32768;
            gb[n] = -32768;
        end
        run_frame("t5_max", 1'b1, 1'b0, 1'b0);
        chk("t5.peak_exact", longint'($signed(corr_peak)), 64'sd68719476736);

        for (int i = 0; i < 4; i++) begin
            rand_shift(int'($urandom_range(30, 0)) - 15, 3000);
            run_frame($sformatf("rnd%0d", i), i[0], i > 0, 1'b0);
        end
        rand_shift(0, 32767);
        for (int n = 0; n < FRAME; n++)
            gb[n] = int'($urandom_range(65535, 0)) - 32768;
        run_frame("rnd_full", 1'b1, 1'b1, 1'b0);

        rand_shift(9, 2000);
        feed(1'b0, 1'b0);
        repeat (500) @(posedge clk_60MHz);
        #1;
        chk("t6.busy_mid", longint'(busy), 1);
        ec = ena_cnt;
        rst_n = 1'b0;
        #1;
        chk("t6.rst_busy", longint'(busy), 0);
        chk("t6.rst_ena", longint'(ena), 0);
        chk("t6.rst_lag", longint'(lag_diff), 0);
        chk("t6.rst_peak", longint'(corr_peak), 0);
        repeat (4) @(posedge clk_60MHz);
        #1;
        rst_n = 1'b1;
        repeat (LAT + 20) @(posedge clk_60MHz);
        #1;
        chk("t6.no_ena", ena_cnt, ec);
        chk("t6.post_busy", longint'(busy), 0);

        clear_frame(); ga[10] = 2000; gb[13] = 2000;
        run_frame("t6_fresh", 1'b0, 1'b0, 1'b1);
        chk("t6.lag_exact", longint'($signed(lag_diff)), 3);

        rand_shift(-4, 1500);
        run_frame("t6_next", 1'b0, 1'b1, 1'b1);

        repeat (3) @(posedge clk_60MHz);
        #1;
        chk("ena_total", ena_cnt, frames);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xcorr_lag_finder.md
Name: xcorr_lag_finder

Overview:
- Producer of the signed lag estimate consumed by the angle-calculation stage.
- Captures one frame of PCM samples from each of two microphones.
- Computes the cross-correlation over a symmetric lag window using one sequential MAC, then reports the lag with the peak correlation.
- Output is a signed lag plus a one-cycle enable pulse, once per frame, running in the 60 MHz system domain.

Parameters:
- DW, 16, signed sample width.
- FRAME, 64, samples per channel per frame; power of two.
- MAX_LAG, 15, lags searched are -MAX_LAG..+MAX_LAG; must be ≤31 to fit lag_diff.
- ACC_W, 2*DW+$clog2(FRAME)+1 (default 39), signed accumulator and peak width.

Ports:
- clk_60MHz, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- sample_valid, input, 1, one sample pair present this cycle.
- mic_a, input, DW, signed sample of microphone A.
- mic_b, input, DW, signed sample of microphone B.
- busy, output, 1, high while in CALC; sample pairs are discarded while high.
- lag_diff, output, 6, signed lag of the correlation peak; positive means B lags A.
- corr_peak, output, ACC_W, signed peak correlation value.
- ena, output, 1, one-cycle pulse when lag_diff/corr_peak update.

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to CAPTURE with sample count 0.
  - busy=0, ena=0, lag_diff=0, corr_peak=0.
  - Buffer contents are don't-care.
- CAPTURE:
  - Each cycle with sample_valid=1 writes mic_a to bufA[cnt] and mic_b to bufB[cnt], then cnt++.
  - On the edge that writes index FRAME-1: cnt wraps to 0, FSM goes to CALC, busy=1 from the next cycle.
- CALC:
  - Iterates k from -MAX_LAG to +MAX_LAG ascending. For each k, iterates n from 0 to FRAME-1, one (k,n) pair per cycle.
  - Term is bufA[n]*bufB[n+k] when 0≤n+k<FRAME, else 0. Out-of-range pairs still consume a cycle.
  - R(k) = sum of all FRAME terms.
  - Products are full 2*DW signed; accumulation is sign-extended to ACC_W with no saturation (it cannot overflow).
  - Pipeline: address/read, multiply register, accumulate. At the end of each lag, R(k) is compared against the running max.
  - The running max is initialised with R(-MAX_LAG). It is replaced only if R(k) is strictly greater, so ties keep the most negative lag.
  - sample_valid is ignored throughout CALC; dropped samples are not counted.
- DONE (one cycle):
  - lag_diff ← argmax k (two's complement, 6 bits), corr_peak ← max R, ena=1, busy=0.
  - FSM returns to CAPTURE with cnt=0. A sample_valid in this cycle is accepted as index 0.
- Latency: ena is high exactly (2*MAX_LAG+1)*FRAME+3 cycles after the edge that captured sample FRAME-1. For defaults that is 1987 cycles.
- Outputs:
  - ena is high for exactly one cycle per frame.
  - lag_diff and corr_peak hold their values until the next DONE.
- Frame rate constraint: with defaults, the next frame needs 64 samples × 640 cycles at 93.75 kHz, well above the 1987-cycle compute time, so no frames are lost in normal operation.
- Reset mid-CALC or mid-CAPTURE: the partial frame is abandoned, no ena is generated, and outputs return to their reset values.
- sample_valid is never asserted on consecutive cycles in the system, but the block must accept back-to-back valids in CAPTURE.

Test Plan:
1. Both channels zero except 1000 at n=20 in A and B -> ena once at cycle 1987 after last sample, lag_diff=0, corr_peak=1000000.
2. A impulse 1000 at n=20, B impulse 1000 at n=25 -> lag_diff=+5 (6'b000101), corr_peak=1000000.
3. A impulse 1000 at n=30, B impulse 1000 at n=23 -> lag_diff=-7 (6'b111001); B impulse at n=50 (offset +20, outside window) -> lag_diff=-15, corr_peak=0.
4. All samples zero -> every R(k)=0, tie rule gives lag_diff=-15 (6'b110001), corr_peak=0, ena pulse still produced.
5. All 64 samples of A and B = -32768 -> R(0)=2^36 is the strict peak, lag_diff=0, corr_peak=68719476736, no wrap.
6. Assert rst_n low 500 cycles into CALC, then feed a fresh frame with +3 offset. Check:
   - no ena during or right after reset;
   - samples fed during busy are not captured;
   - after the fresh frame, ena pulses once with lag_diff=+3.
